vector_loader: RTL and testbench
================================

VECTOR_LOADER -- requirements
Module: vector_loader

Interface
REQ-001 Parameter DIM, 8, number of elements per vector; legal range is 1 or more.
REQ-002 Parameter A_DATA_WIDTH, 32, bit-width of one A element.
REQ-003 Parameter B_DATA_WIDTH, 32, bit-width of one B element.
REQ-004 Clock  input  1  the single clock; all logic is rising-edge.
REQ-005 Reset  input  1  synchronous, active-high reset.
REQ-006 InValid  input  1  InA/InB carry a valid element pair.
REQ-007 InReady  output  1  loader accepts the element pair this cycle.
REQ-008 InA  input  A_DATA_WIDTH  element a_i.
REQ-009 InB  input  B_DATA_WIDTH  element b_i.
REQ-010 OutValid  output  1  A/B hold a complete vector pair.
REQ-011 OutReady  input  1  downstream dot-product stage takes the vector pair.
REQ-012 A  output  DIM*A_DATA_WIDTH  packed vector; element i at bits [i*A_DATA_WIDTH +: A_DATA_WIDTH].
REQ-013 B  output  DIM*B_DATA_WIDTH  packed vector; element i at bits [i*B_DATA_WIDTH +: B_DATA_WIDTH].

Function
REQ-014 An element is accepted in a cycle where InValid and InReady are both 1; InA and InB are written into slot Count of their bank.
REQ-015 Count SHALL be CLOG2(DIM) bits wide (minimum 1), increment by 1 per accept, and wrap from DIM-1 to 0.
REQ-016 The base state machine SHALL have two states, FILL and FULL: FILL drives InReady=1 and OutValid=0; FULL drives InReady=0 and OutValid=1.
REQ-017 FILL SHALL go to FULL on the cycle after the accept into slot DIM-1; with DIM=1, every accept goes to FULL.
REQ-018 FULL SHALL go to FILL, with Count=0, on the cycle after OutValid and OutReady are both 1.
REQ-019 A and B SHALL be registered and held stable while OutValid=1 and OutReady=0.
REQ-020 Minimum latency SHALL be 1 cycle: the element accepted into slot DIM-1 at edge N gives OutValid=1 after edge N.
REQ-021 OutReady asserted in FILL SHALL have no effect; InValid asserted while InReady=0 SHALL be ignored, with no data corruption.
REQ-022 No arithmetic is performed; element bits pass through unmodified.

Reset
REQ-023 Reset SHALL force state FILL, Count=0, OutValid=0, InReady=1, A=0 and B=0, on the next clock edge.
REQ-024 Reset mid-fill or in FULL SHALL discard the partial or pending vector; an element presented in the reset cycle is not accepted.

Configuration
REQ-025 Macro VECTOR_LOADER_DOUBLE_BUF_EN SHALL select double buffering; when it is undefined, REQ-016 to REQ-018 apply exactly.
REQ-026 With the macro defined, two banks SHALL alternate as write bank and read bank.
  - InReady=0 only when both banks are full.
  - OutValid=1 whenever the read bank is full.
REQ-027 With the macro defined, completing a fill in the same cycle as an output handshake SHALL give back-to-back OutValid with no bubble.
REQ-028 With the macro defined, sustained InValid=1 and OutReady=1 SHALL give one vector every DIM cycles.
REQ-029 With the macro defined, vectors SHALL be delivered in strict acceptance order.

Structure
REQ-030 The CLOG2 macro and the state encodings (FILL, FULL) SHALL live in the shared include/package mme_defs.
REQ-031 One sub-module, vector_bank, SHALL hold a single DIM-slot A/B register pair with a write port and a full flag.
  - Instantiated once without VECTOR_LOADER_DOUBLE_BUF_EN, twice with it.
REQ-032 Port A/B SHALL connect directly to dotProduct ports A/B with the same DIM and widths.

Verification
REQ-033 DIM=4, widths 8: InA=1,2,3,4 and InB=5,6,7,8 with OutReady=1 -> A=0x04030201, B=0x08070605, OutValid=1 for exactly one cycle.
REQ-034 OutReady held 0 for 5 cycles in FULL -> A/B are unchanged, InReady=0 (base build), and a 5th element offered is not accepted.
REQ-035 Reset after 2 accepts -> the next 4 elements 9,10,11,12 give A=0x0C0B0A09.
REQ-036 DIM=1: elements 0xAA and 0xBB with OutReady=1 -> two vectors, A=0xAA and then A=0xBB.
REQ-037 VECTOR_LOADER_DOUBLE_BUF_EN build with continuous InValid/OutReady over 16 elements -> 4 vectors, OutValid pulses every 4 cycles, InReady never 0.
REQ-038 Random InValid/OutReady stalls for 1000 vectors -> a scoreboard shows in-order, bit-exact delivery in both builds.

Source files
------------

// File: rtl/mme_defs.sv
// Shared definitions for the matrix/vector engine: CLOG2 helper and loader fill states.
`ifndef MME_DEFS_SV
`define MME_DEFS_SV

`define CLOG2(x) (((x) > 1) ? $clog2(x) : 1)

package mme_defs;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } fill_state_t;

endpackage

`endif

// File: rtl/vector_bank.sv
// One DIM-slot A/B register bank with an indexed write port and a FILL/FULL flag.
module vector_bank
    import mme_defs::*;
#(
    parameter int DIM = 8,
    parameter int AW  = 32,
    parameter int BW  = 32,
    parameter int CW  = 3
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              wr_en,
    input  logic [CW-1:0]     wr_idx,
    input  logic [AW-1:0]     wr_a,
    input  logic [BW-1:0]     wr_b,
    input  logic              set_full,
    input  logic              clr_full,
    output logic [DIM*AW-1:0] A,
    output logic [DIM*BW-1:0] B,
    output logic              full
);

    fill_state_t state;
    fill_state_t state_next;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FILL:    if (set_full) state_next = FULL;
            FULL:    if (clr_full) state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    assign full = (state == FULL);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            A <= '0;
            B <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < DIM; i++) begin
                if (wr_idx == CW'(i)) begin
                    A[i*AW +: AW] <= wr_a;
                    B[i*BW +: BW] <= wr_b;
                end
            end
        end
    end

endmodule

// File: rtl/vector_loader.sv
// Serial-to-parallel A/B vector loader feeding the dot-product stage.
// Define VECTOR_LOADER_DOUBLE_BUF_EN for ping-pong banks (fill one while the other drains).
module vector_loader #(
    parameter int DIM          = 8,
    parameter int A_DATA_WIDTH = 32,
    parameter int B_DATA_WIDTH = 32
) (
    input  logic                        Clock,
    input  logic                        Reset,
    input  logic                        InValid,
    output logic                        InReady,
    input  logic [A_DATA_WIDTH-1:0]     InA,
    input  logic [B_DATA_WIDTH-1:0]     InB,
    output logic                        OutValid,
    input  logic                        OutReady,
    output logic [DIM*A_DATA_WIDTH-1:0] A,
    output logic [DIM*B_DATA_WIDTH-1:0] B
);

    localparam int CW = `CLOG2(DIM);
`ifdef VECTOR_LOADER_DOUBLE_BUF_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic [CW-1:0] count;
    logic          accept;
    logic          last;
    logic          handshake;
    logic [NB-1:0] full;
    logic [NB-1:0] wr_en;
    logic [NB-1:0] clr_full;
    logic [DIM*A_DATA_WIDTH-1:0] bank_a [NB];
    logic [DIM*B_DATA_WIDTH-1:0] bank_b [NB];

    assign accept    = InValid && InReady;
    assign handshake = OutValid && OutReady;
    assign last      = (count == CW'(DIM - 1));

    // Write slot wraps on the last accept, so a full bank always restarts at 0.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            count <= '0;
        end else if (accept) begin
            count <= last ? '0 : count + 1'b1;
        end
    end

`ifdef VECTOR_LOADER_DOUBLE_BUF_EN
    logic wr_sel;
    logic rd_sel;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
        end else begin
            if (accept && last) wr_sel <= ~wr_sel;
            if (handshake) rd_sel <= ~rd_sel;
        end
    end

    assign InReady  = ~full[wr_sel];
    assign OutValid = full[rd_sel];
    assign A        = bank_a[rd_sel];
    assign B        = bank_b[rd_sel];

    for (genvar i = 0; i < NB; i++) begin : g_sel
        assign wr_en[i]    = accept && (wr_sel == 1'(i));
        assign clr_full[i] = handshake && (rd_sel == 1'(i));
    end
`else
    assign InReady     = ~full[0];
    assign OutValid    = full[0];
    assign A           = bank_a[0];
    assign B           = bank_b[0];
    assign wr_en[0]    = accept;
    assign clr_full[0] = handshake;
`endif

    for (genvar i = 0; i < NB; i++) begin : g_bank
        vector_bank #(
            .DIM (DIM),
            .AW  (A_DATA_WIDTH),
            .BW  (B_DATA_WIDTH),
            .CW  (CW)
        ) u_bank (
            .Clock    (Clock),
            .Reset    (Reset),
            .wr_en    (wr_en[i]),
            .wr_idx   (count),
            .wr_a     (InA),
            .wr_b     (InB),
            .set_full (wr_en[i] && last),
            .clr_full (clr_full[i]),
            .A        (bank_a[i]),
            .B        (bank_b[i]),
            .full     (full[i])
        );
    end

endmodule

// File: tb/tb_vector_loader.sv
// Directed and scoreboarded bench for vector_loader (DIM=4 and DIM=1, 8-bit elements).
module tb_vector_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        iv, ordy, ir, ov;
    logic [7:0]  ia, ib;
    logic [31:0] a, b;
    logic        iv1, ordy1, ir1, ov1;
    logic [7:0]  ia1, ib1, a1, b1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    vector_loader #(.DIM(4), .A_DATA_WIDTH(8), .B_DATA_WIDTH(8)) dut4 (
        .Clock(clk), .Reset(rst), .InValid(iv), .InReady(ir),
        .InA(ia), .InB(ib), .OutValid(ov), .OutReady(ordy), .A(a), .B(b)
    );

    vector_loader #(.DIM(1), .A_DATA_WIDTH(8), .B_DATA_WIDTH(8)) dut1 (
        .Clock(clk), .Reset(rst), .InValid(iv1), .InReady(ir1),
        .InA(ia1), .InB(ib1), .OutValid(ov1), .OutReady(ordy1), .A(a1), .B(b1)
    );

    typedef struct packed {
        logic [3:0][7:0] ea;
        logic [3:0][7:0] eb;
        logic [31:0]     xa;
        logic [31:0]     xb;
        logic [3:0]      stall;
    } vec_t;

    vec_t tbl [3];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push4(input logic [7:0] x, input logic [7:0] y);
        iv = 1'b1;
        ia = x;
        ib = y;
        chk("push_ready", 32'(ir), 32'd1);
        step();
        iv = 1'b0;
    endtask

    initial begin
        logic [31:0] qa[$];
        logic [31:0] qb[$];
        logic [31:0] pa, pb, ex;
        int ne, nv, cyc, pulses, lastp;

        tbl[0] = '{ea: {8'd4, 8'd3, 8'd2, 8'd1}, eb: {8'd8, 8'd7, 8'd6, 8'd5},
                   xa: 32'h04030201, xb: 32'h08070605, stall: 4'd0};
        tbl[1] = '{ea: {8'hef, 8'hbe, 8'had, 8'hde}, eb: {8'h44, 8'h33, 8'h22, 8'h11},
                   xa: 32'hefbeadde, xb: 32'h44332211, stall: 4'd5};
        tbl[2] = '{ea: {8'h7f, 8'h80, 8'h00, 8'hff}, eb: {8'h08, 8'h04, 8'h02, 8'h01},
                   xa: 32'h7f8000ff, xb: 32'h08040201, stall: 4'd2};

        rst = 1'b1;
        iv = 1'b0; ordy = 1'b0; ia = '0; ib = '0;
        iv1 = 1'b0; ordy1 = 1'b0; ia1 = '0; ib1 = '0;
        step();
        step();
        rst = 1'b0;
        chk("rst_ready", 32'(ir), 32'd1);
        chk("rst_valid", 32'(ov), 32'd0);
        chk("rst_a", a, 32'd0);
        chk("rst_b", b, 32'd0);

        for (int v = 0; v < 3; v++) begin
            ordy = (tbl[v].stall == 0);
            for (int j = 0; j < 4; j++) push4(tbl[v].ea[j], tbl[v].eb[j]);
            chk("vec_valid", 32'(ov), 32'd1);
            chk("vec_a", a, tbl[v].xa);
            chk("vec_b", b, tbl[v].xb);
            for (int k = 0; k < int'(tbl[v].stall); k++) begin
`ifdef VECTOR_LOADER_DOUBLE_BUF_EN
                chk("stall_ready", 32'(ir), 32'd1);
`else
                iv = 1'b1;
                ia = 8'h99;
                ib = 8'h99;
                chk("stall_ready", 32'(ir), 32'd0);
`endif
                step();
                chk("stall_valid", 32'(ov), 32'd1);
                chk("stall_a", a, tbl[v].xa);
                chk("stall_b", b, tbl[v].xb);
            end
            iv = 1'b0;
            ordy = 1'b1;
            step();
            chk("drain_valid", 32'(ov), 32'd0);
            chk("drain_ready", 32'(ir), 32'd1);
            ordy = 1'b0;
        end

        push4(8'h55, 8'h55);
        push4(8'h66, 8'h66);
        rst = 1'b1;
        iv = 1'b1;
        ia = 8'h77;
        ib = 8'h77;
        step();
        rst = 1'b0;
        iv = 1'b0;
        chk("midrst_a", a, 32'd0);
        chk("midrst_valid", 32'(ov), 32'd0);
        push4(8'd9, 8'h21);
        push4(8'd10, 8'h22);
        push4(8'd11, 8'h23);
        push4(8'd12, 8'h24);
        chk("midrst_vec_valid", 32'(ov), 32'd1);
        chk("midrst_vec_a", a, 32'h0c0b0a09);
        chk("midrst_vec_b", b, 32'h24232221);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("fullrst_valid", 32'(ov), 32'd0);
        chk("fullrst_a", a, 32'd0);
        chk("fullrst_ready", 32'(ir), 32'd1);

        ordy1 = 1'b1;
        iv1 = 1'b1; ia1 = 8'haa; ib1 = 8'h11;
        chk("d1_ready", 32'(ir1), 32'd1);
        step();
        iv1 = 1'b0;
        chk("d1_valid0", 32'(ov1), 32'd1);
        chk("d1_a0", 32'(a1), 32'h000000aa);
        step();
        chk("d1_drain0", 32'(ov1), 32'd0);
        iv1 = 1'b1; ia1 = 8'hbb; ib1 = 8'h22;
        step();
        iv1 = 1'b0;
        chk("d1_valid1", 32'(ov1), 32'd1);
        chk("d1_a1", 32'(a1), 32'h000000bb);
        chk("d1_b1", 32'(b1), 32'h00000022);
        step();
        chk("d1_drain1", 32'(ov1), 32'd0);
        ordy1 = 1'b0;

`ifdef VECTOR_LOADER_DOUBLE_BUF_EN
        pulses = 0;
        lastp = -1;
        ordy = 1'b1;
        for (int c = 0; c < 20; c++) begin
            iv = (c < 16);
            ia = 8'(c + 1);
            ib = 8'(c + 101);
            if (c < 16) chk("db_ready", 32'(ir), 32'd1);
            step();
            if (ov) begin
                ex = {8'(4*pulses+4), 8'(4*pulses+3), 8'(4*pulses+2), 8'(4*pulses+1)};
                chk("db_a", a, ex);
                if (lastp >= 0) chk("db_gap", 32'(c - lastp), 32'd4);
                lastp = c;
                pulses++;
            end
        end
        chk("db_pulses", 32'(pulses), 32'd4);
        iv = 1'b0;
        ordy = 1'b0;
`endif

        ne = 0;
        nv = 0;
        cyc = 0;
        pa = '0;
        pb = '0;
        while (nv < 1000 && cyc < 40000) begin
            iv = (ne < 4000) && ($urandom_range(0, 3) != 0);
            ia = 8'($urandom);
            ib = 8'($urandom);
            ordy = ($urandom_range(0, 2) != 0);
            #1;
            if (iv && ir) begin
                pa = {ia, pa[31:8]};
                pb = {ib, pb[31:8]};
                ne++;
                if (ne % 4 == 0) begin
                    qa.push_back(pa);
                    qb.push_back(pb);
                end
            end
            if (ov && ordy) begin
                if (qa.size() == 0) begin
                    chk("sb_unexpected", 32'(ov), 32'd0);
                end else begin
                    chk("sb_a", a, qa.pop_front());
                    chk("sb_b", b, qb.pop_front());
                end
                nv++;
            end
            step();
            cyc++;
        end
        chk("sb_count", 32'(nv), 32'd1000);
        iv = 1'b0;
        ordy = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
